// File: rtl/addpipe_pkg.sv
// Shared constants and result type for the prefix-adder result collector.
package addpipe_pkg;

    localparam int unsigned ADD_LATENCY = 7;
    localparam int unsigned ADD_WIDTH   = 32;

    typedef struct packed {
        logic                 cout;
        logic [ADD_WIDTH-1:0] sum;
    } add_result_t;

endpackage

// File: rtl/addpipe_res_fifo.sv
// Synchronous FIFO with a registered head entry; occupancy counter decides full/empty.
module addpipe_res_fifo #(
    parameter int unsigned DEPTH   = 8,
    parameter type         entry_t = logic [32:0]
) (
    input  logic   i_clk,
    input  logic   i_rst_n,
    input  logic   i_push,
    input  entry_t i_data,
    input  logic   i_pop,
    output logic   o_valid,
    output entry_t o_data
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    entry_t        r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_cnt;
    entry_t        r_head;
    logic          r_valid;

    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_cnt_nxt;
    entry_t        w_head_nxt;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        w_full    = (r_cnt == CW'(DEPTH));
        w_pop     = i_pop && r_valid;
        w_push    = i_push && (!w_full || w_pop);
        w_cnt_nxt = r_cnt + CW'(w_push) - CW'(w_pop);

        // The head register mirrors mem[rd_ptr]; refresh it whenever the head entry changes.
        w_head_nxt = r_head;
        if (w_pop) begin
            if (r_cnt > CW'(1)) begin
                w_head_nxt = r_mem[ptr_inc(r_rd_ptr)];
            end else if (w_push) begin
                w_head_nxt = i_data;
            end
        end else if ((r_cnt == '0) && w_push) begin
            w_head_nxt = i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_head   <= '0;
            r_valid  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_cnt   <= w_cnt_nxt;
            r_head  <= w_head_nxt;
            r_valid <= (w_cnt_nxt != '0);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_head;

endmodule

// File: rtl/addpipe_collector.sv
// Result collector for the pipelined prefix adder: valid delay line, credit counter, result FIFO.
// Define ADDPIPE_TAG_EN to carry a per-launch tag alongside each result.
module addpipe_collector
    import addpipe_pkg::*;
#(
    parameter int unsigned LATENCY = ADD_LATENCY,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned WIDTH   = ADD_WIDTH,
    parameter int unsigned TAG_W   = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_op_valid,
    output logic             o_op_ready,
    input  logic [WIDTH-1:0] i_add_s,
    input  logic             i_add_cout,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out_sum,
    output logic             o_out_cout
`ifdef ADDPIPE_TAG_EN
    ,
    input  logic [TAG_W-1:0] i_op_tag,
    output logic [TAG_W-1:0] o_out_tag
`endif
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

`ifdef ADDPIPE_TAG_EN
    typedef struct packed {
        logic [TAG_W-1:0] tag;
        add_result_t      res;
    } entry_t;
`else
    typedef struct packed {
        add_result_t res;
    } entry_t;
`endif

    logic [LATENCY-1:0] r_vld;
    logic [CW-1:0]      r_cnt;
    logic               w_launch;
    logic               w_pop;
    logic               w_arr;
    logic [CW-1:0]      w_cnt_nxt;
    entry_t             w_push_data;
    entry_t             w_head;

    // Credits cover in-flight launches plus queued results, so a push never meets a full FIFO.
    assign o_op_ready = (r_cnt < CW'(DEPTH));
    assign w_launch   = i_op_valid && o_op_ready;
    assign w_pop      = o_out_valid && i_out_ready;
    assign w_cnt_nxt  = r_cnt + CW'(w_launch) - CW'(w_pop);
    assign w_arr      = r_vld[LATENCY-1];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vld <= '0;
            r_cnt <= '0;
        end else begin
            r_vld[0] <= w_launch;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
            end
            r_cnt <= w_cnt_nxt;
        end
    end

`ifdef ADDPIPE_TAG_EN
    logic [TAG_W-1:0] r_tag [LATENCY];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_tag[0] <= i_op_tag;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end
`endif

    always_comb begin
        w_push_data          = '0;
        w_push_data.res.cout = i_add_cout;
        w_push_data.res.sum  = i_add_s;
`ifdef ADDPIPE_TAG_EN
        w_push_data.tag      = r_tag[LATENCY-1];
`endif
    end

    addpipe_res_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_res_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_arr),
        .i_data  (w_push_data),
        .i_pop   (i_out_ready),
        .o_valid (o_out_valid),
        .o_data  (w_head)
    );

    assign o_out_sum  = w_head.res.sum;
    assign o_out_cout = w_head.res.cout;
`ifdef ADDPIPE_TAG_EN
    assign o_out_tag  = w_head.tag;
`endif

endmodule
